// File: rtl/palindrome_pkg.sv
// palindrome_pkg
//   Shared definitions for the 3-digit decimal palindrome generator:
//   the value range, the BCD digit width, the FSM state encoding and a helper
//   that turns the two distinct digits (d2,d1) into the binary value d2 d1 d2.
package palindrome_pkg;

  localparam int unsigned PAL_MIN = 101;
  localparam int unsigned PAL_MAX = 999;
  localparam int unsigned BCD_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // d2 d1 d2 = d2*100 + d1*10 + d2 = d2*101 + d1*10; max 999 fits 10 bits.
  function automatic logic [9:0] pal_value(input logic [BCD_W-1:0] d2,
                                           input logic [BCD_W-1:0] d1);
    logic [9:0] d2_ext;
    logic [9:0] d1_ext;
    d2_ext = {{(10-BCD_W){1'b0}}, d2};
    d1_ext = {{(10-BCD_W){1'b0}}, d1};
    return (d2_ext * 10'd101) + (d1_ext * 10'd10);
  endfunction

endpackage

// File: rtl/palindrome_step.sv
// palindrome_step
//   Combinational successor of a 3-digit palindrome given by its digits.
//   Ports:
//     d2_i, d1_i  current outer / middle BCD digit
//     wrap_i      1: 999 is followed by 101; 0: 999 is the end of the range
//     d2_o, d1_o  digits of the next palindrome
//     last_o      current value is 999 (top of the range)
module palindrome_step
  import palindrome_pkg::*;
(
  input  logic [BCD_W-1:0] d2_i,
  input  logic [BCD_W-1:0] d1_i,
  input  logic             wrap_i,
  output logic [BCD_W-1:0] d2_o,
  output logic [BCD_W-1:0] d1_o,
  output logic             last_o
);

  localparam logic [BCD_W-1:0] DIG_NINE = BCD_W'(9);
  localparam logic [BCD_W-1:0] DIG_ONE  = BCD_W'(1);
  localparam logic [BCD_W-1:0] DIG_ZERO = BCD_W'(0);

  always_comb begin
    d2_o   = d2_i;
    d1_o   = d1_i;
    last_o = (d2_i == DIG_NINE) && (d1_i == DIG_NINE);
    if (d1_i < DIG_NINE) begin
      d1_o = d1_i + DIG_ONE;
    end else if (d2_i < DIG_NINE) begin
      d1_o = DIG_ZERO;
      d2_o = d2_i + DIG_ONE;
    end else if (wrap_i) begin
      // 999 -> 101
      d2_o = DIG_ONE;
      d1_o = DIG_ZERO;
    end
    // 999 without wrap: digits hold; the caller ends the run on last_o.
  end

endmodule

// File: rtl/palindrome_generator.sv
// palindrome_generator
//   Streams successive 3-digit decimal palindromes (d2 d1 d2) starting at a
//   caller-supplied prefix, COUNT values, one per accepted valid/ready beat.
//   Ports:
//     clk, rst                 clock (rising edge), async active-high reset
//     start                    request pulse, honoured only in IDLE
//     start_d2, start_d1       BCD digits of the first value
//     count                    number of values to emit (>=1)
//     number                   registered binary value of the current palindrome
//     d2, d1, d0               registered BCD digits (d0 mirrors d2)
//     out_valid, out_ready     output handshake
//     busy                     high while running
//     done, truncated          one-cycle completion pulse; truncated flags a
//                              non-wrapping run that hit 999 before COUNT
//     err                      one-cycle pulse for a start with illegal inputs
module palindrome_generator
  import palindrome_pkg::*;
#(
  parameter bit WRAP  = 1'b1,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BCD_W-1:0] start_d2,
  input  logic [BCD_W-1:0] start_d1,
  input  logic [CNT_W-1:0] count,
  output logic [9:0]       number,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             truncated,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] d2_q, d2_d;
  logic [BCD_W-1:0] d1_q, d1_d;
  logic [9:0]       number_q, number_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             truncated_q, truncated_d;
  logic             err_q, err_d;

  logic [BCD_W-1:0] step_d2;
  logic [BCD_W-1:0] step_d1;
  logic             step_last;
  logic             start_legal;
  logic             xfer;
  logic             final_beat;

  palindrome_step u_step (
    .d2_i   (d2_q),
    .d1_i   (d1_q),
    .wrap_i (WRAP),
    .d2_o   (step_d2),
    .d1_o   (step_d1),
    .last_o (step_last)
  );

  assign start_legal = (start_d2 != '0) && (start_d2 <= BCD_W'(9)) &&
                       (start_d1 <= BCD_W'(9)) && (count != '0);

  assign xfer = out_valid_q && out_ready;

  // The run ends on the last requested beat, or at 999 when not wrapping.
  assign final_beat = (remaining_q <= CNT_ONE) || (step_last && !WRAP);

  always_comb begin
    state_d     = state_q;
    d2_d        = d2_q;
    d1_d        = d1_q;
    number_d    = number_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    truncated_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            d2_d        = start_d2;
            d1_d        = start_d1;
            number_d    = pal_value(start_d2, start_d1);
            remaining_d = count;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (xfer) begin
          if (final_beat) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            truncated_d = step_last && !WRAP && (remaining_q > CNT_ONE);
            state_d     = DONE;
          end else begin
            d2_d        = step_d2;
            d1_d        = step_d1;
            number_d    = pal_value(step_d2, step_d1);
            remaining_d = remaining_q - CNT_ONE;
          end
        end
      end

      DONE: begin
        // done/truncated are visible this cycle; any start here is dropped.
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d2_q        <= '0;
      d1_q        <= '0;
      number_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      truncated_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d2_q        <= d2_d;
      d1_q        <= d1_d;
      number_q    <= number_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      truncated_q <= truncated_d;
      err_q       <= err_d;
    end
  end

  assign number    = number_q;
  assign d2        = d2_q;
  assign d1        = d1_q;
  assign d0        = d2_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truncated = truncated_q;
  assign err       = err_q;

endmodule
